// File: rtl/fifo_pkg.sv
// Shared constants for the stream FIFO family: full-policy selectors and the
// drop counter width.
package fifo_pkg;

  localparam int FULL_POLICY_BACKPRESSURE = 0;
  localparam int FULL_POLICY_DROP         = 1;
  localparam int DROP_CNT_W               = 16;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with enable.
// Contents are not reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_fifo_v2.sv
// Valid/ready ring-buffer FIFO with a first-word-fall-through output register,
// level-based almost flags, selectable full policy and sticky error events.
module stream_fifo_v2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AF_LEVEL   = 1020,
  parameter int AE_LEVEL   = 4,
  parameter int DROP_MODE  = FULL_POLICY_BACKPRESSURE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       clr_events,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       event_overflow,
  output logic                       event_underrun,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(AE_LEVEL);
  localparam bit DROP_EN = (DROP_MODE == FULL_POLICY_DROP);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [LVL_W-1:0]      ram_level;
  logic full, push, pop, load;
  logic overflow_hit, underrun_hit, drop_hit;

  // level counts the output register too, so the RAM holds level minus out_vld
  assign ram_level    = level - LVL_W'(out_vld);
  assign full         = (level == FULL_LVL);
  assign push         = in_vld & ~full & ~flush;
  assign pop          = out_vld & out_rdy & ~flush;
  assign load         = (~out_vld | out_rdy) & (ram_level != '0) & ~flush;
  assign overflow_hit = in_vld & full & ~flush;
  assign underrun_hit = out_rdy & (level == '0) & ~flush;
  assign drop_hit     = DROP_EN & overflow_hit;

  assign in_rdy       = DROP_EN ? 1'b1 : ~full;
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);
  // The RAM read register is the output register; mask it while it holds nothing
  assign out_data     = out_vld ? ram_rdata : '0;

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .re   (load),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      out_vld        <= 1'b0;
      event_overflow <= 1'b0;
      event_underrun <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        out_vld <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (load) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      level <= level + LVL_W'(1);
        else if (pop && !push) level <= level - LVL_W'(1);
        if (load)     out_vld <= 1'b1;
        else if (pop) out_vld <= 1'b0;
      end
      // A new trigger beats a simultaneous clear
      event_overflow <= overflow_hit | (event_overflow & ~clr_events);
      event_underrun <= underrun_hit | (event_underrun & ~clr_events);
      if (clr_events)                  drop_cnt <= DROP_CNT_W'(drop_hit);
      else if (drop_hit && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_fifo_v2.sv
// Bench for stream_fifo_v2: a backpressure and a drop-mode instance share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_stream_fifo_v2;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, clr_events = 1'b0, in_vld = 1'b0, out_rdy = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_rdy_o [2];
  logic [DW-1:0] out_data_o [2];
  logic          out_vld_o [2];
  logic [3:0]    level_o [2];
  logic          af_o [2], ae_o [2], ov_o [2], un_o [2];
  logic [15:0]   drop_o [2];

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  word_t mq [2][$];
  int    m_edge = 0;
  bit    m_ov [2];
  bit    m_un [2];
  int    m_drop [2];
  logic [DW-1:0] popped [$];

  logic [DW-1:0] exp_t4 [11] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15,
                                 32'h16, 32'h17, 32'h21, 32'h22, 32'h23};

  always #5 clk = ~clk;

  stream_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .DROP_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .clr_events(clr_events),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy_o[0]),
    .out_data(out_data_o[0]), .out_vld(out_vld_o[0]), .out_rdy(out_rdy),
    .level(level_o[0]), .almost_full(af_o[0]), .almost_empty(ae_o[0]),
    .event_overflow(ov_o[0]), .event_underrun(un_o[0]), .drop_cnt(drop_o[0])
  );

  stream_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .DROP_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .clr_events(clr_events),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy_o[1]),
    .out_data(out_data_o[1]), .out_vld(out_vld_o[1]), .out_rdy(out_rdy),
    .level(level_o[1]), .almost_full(af_o[1]), .almost_empty(ae_o[1]),
    .event_overflow(ov_o[1]), .event_underrun(un_o[1]), .drop_cnt(drop_o[1])
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [DW-1:0] data, input logic rdy,
                               input logic fl, input logic clr);
    in_vld     = vld;
    in_data    = data;
    out_rdy    = rdy;
    flush      = fl;
    clr_events = clr;
    @(posedge clk);
    #1;
  endtask

  // A word is visible at the head from the edge after the one that stored it
  function automatic bit modelVld(int m);
    return (mq[m].size() > 0) && (mq[m][0].t < m_edge);
  endfunction

  initial begin
    bit full, ov, un, drop, do_pop;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int m = 0; m < 2; m++) begin
          mq[m].delete();
          m_ov[m] = 1'b0;
          m_un[m] = 1'b0;
          m_drop[m] = 0;
        end
      end else begin
        for (int m = 0; m < 2; m++) begin
          ov = 1'b0;
          un = 1'b0;
          drop = 1'b0;
          full = (mq[m].size() == DEPTH);
          if (flush) begin
            mq[m].delete();
          end else begin
            do_pop = modelVld(m) && out_rdy;
            ov   = in_vld && full;
            drop = ov && (m == 1);
            un   = out_rdy && (mq[m].size() == 0);
            if (do_pop) void'(mq[m].pop_front());
            if (in_vld && !full) mq[m].push_back(word_t'{in_data, m_edge + 1});
          end
          m_ov[m] = ov | (m_ov[m] & ~clr_events);
          m_un[m] = un | (m_un[m] & ~clr_events);
          if (clr_events)                     m_drop[m] = drop ? 1 : 0;
          else if (drop && m_drop[m] < 65535) m_drop[m] = m_drop[m] + 1;
        end
        m_edge++;
      end
    end
  end

  initial begin
    int sz;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int m = 0; m < 2; m++) begin
          sz = mq[m].size();
          checkOutput($sformatf("level%0d", m), DW'(level_o[m]), DW'(sz));
          checkOutput($sformatf("out_vld%0d", m), DW'(out_vld_o[m]), DW'(modelVld(m)));
          if (modelVld(m)) checkOutput($sformatf("out_data%0d", m), out_data_o[m], mq[m][0].d);
          checkOutput($sformatf("in_rdy%0d", m), DW'(in_rdy_o[m]), DW'((m == 1) || (sz < DEPTH)));
          checkOutput($sformatf("almost_full%0d", m), DW'(af_o[m]), DW'(sz >= AF));
          checkOutput($sformatf("almost_empty%0d", m), DW'(ae_o[m]), DW'(sz <= AE));
          checkOutput($sformatf("ev_overflow%0d", m), DW'(ov_o[m]), DW'(m_ov[m]));
          checkOutput($sformatf("ev_underrun%0d", m), DW'(un_o[m]), DW'(m_un[m]));
          checkOutput($sformatf("drop_cnt%0d", m), DW'(drop_o[m]), DW'(m_drop[m]));
        end
        if (out_vld_o[0] && out_rdy && !flush && !rst) popped.push_back(out_data_o[0]);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    checkOutput("rst_level", DW'(level_o[0]), 0);
    checkOutput("rst_out_vld", DW'(out_vld_o[0]), 0);
    checkOutput("rst_out_data", out_data_o[0], 0);
    checkOutput("rst_in_rdy", DW'(in_rdy_o[0]), 1);
    checkOutput("rst_almost_empty", DW'(ae_o[0]), 1);
    checkOutput("rst_almost_full", DW'(af_o[0]), 0);

    $display("[TB] in-order stream with latency");
    popped.delete();
    applyStimulus(1, 32'h1, 1, 0, 0);
    checkOutput("t1_vld_edge1", DW'(out_vld_o[0]), 0);
    applyStimulus(1, 32'h2, 1, 0, 0);
    checkOutput("t1_vld_edge2", DW'(out_vld_o[0]), 1);
    checkOutput("t1_data_edge2", out_data_o[0], 32'h1);
    applyStimulus(1, 32'h3, 1, 0, 0);
    applyStimulus(1, 32'h4, 1, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t1_level_end", DW'(level_o[0]), 0);
    checkOutput("t1_pop_count", DW'(popped.size()), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("t1_pop_order", (i < popped.size()) ? popped[i] : 32'hDEADBEEF, DW'(i + 1));

    $display("[TB] fill past full in both policies");
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, DW'(32'h10 + i), 0, 0, 0);
    checkOutput("t2_level", DW'(level_o[0]), 8);
    checkOutput("t2_in_rdy", DW'(in_rdy_o[0]), 0);
    checkOutput("t2_almost_full", DW'(af_o[0]), 1);
    checkOutput("t2_overflow", DW'(ov_o[0]), 1);
    checkOutput("t2_drop_cnt_bp", DW'(drop_o[0]), 0);
    applyStimulus(1, 32'h1A, 0, 0, 0);
    checkOutput("t3_drop_cnt", DW'(drop_o[1]), 3);
    checkOutput("t3_in_rdy_drop", DW'(in_rdy_o[1]), 1);

    $display("[TB] push and pop together at full and across wrap");
    popped.delete();
    applyStimulus(1, 32'h20, 1, 0, 0);
    checkOutput("t4_level_full_pp", DW'(level_o[0]), 7);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1, DW'(32'h20 + i), 1, 0, 0);
      checkOutput("t4_level_pp", DW'(level_o[1]), 7);
    end
    repeat (10) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t4_pop_count", DW'(popped.size()), 11);
    for (int i = 0; i < 11; i++)
      checkOutput("t4_pop_order", (i < popped.size()) ? popped[i] : 32'hDEADBEEF, exp_t4[i]);

    $display("[TB] underrun event and clear priority");
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_cleared", DW'(un_o[0]), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t5_underrun", DW'(un_o[0]), 1);
    checkOutput("t5_level", DW'(level_o[0]), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_clr", DW'(un_o[0]), 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("t5_set_wins", DW'(un_o[0]), 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] flush and asynchronous reset");
    for (int i = 0; i < 9; i++) applyStimulus(1, DW'(32'h30 + i), 0, 0, 0);
    checkOutput("t6_drop_before", DW'(drop_o[1]), 1);
    repeat (3) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t6_level5", DW'(level_o[1]), 5);
    applyStimulus(1, 32'h99, 1, 1, 0);
    checkOutput("t6_flush_level", DW'(level_o[1]), 0);
    checkOutput("t6_flush_vld", DW'(out_vld_o[1]), 0);
    checkOutput("t6_flush_drop", DW'(drop_o[1]), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, DW'(32'h40 + i), 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_level", DW'(level_o[0]), 0);
    checkOutput("t6_async_drop", DW'(drop_o[1]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_rst_vld", DW'(out_vld_o[0]), 0);
    checkOutput("t6_rst_data", out_data_o[0], 0);
    checkOutput("t6_rst_ae", DW'(ae_o[0]), 1);
    checkOutput("t6_rst_ov", DW'(ov_o[1]), 0);
    applyStimulus(1, 32'h55, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t6_post_rst_data", out_data_o[1], 32'h55);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
